// File: rtl/median_sched_pkg.sv
// rtl/median_sched_pkg.sv - shared types and constants for the median engine scheduler
package median_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BURST = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int NPIX  = 9;
    localparam int CNT_W = 4;

endpackage

// File: rtl/median_rr_arb.sv
// rtl/median_rr_arb.sv - 2-way round-robin arbiter with last-served pointer
module median_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    // last served requester; 1 after reset so requester 0 wins the first tie
    logic last;

    // remember who was served once a transaction finishes (success or abort)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= served;
        end
    end

    // one-hot grant: on a tie the requester not served last wins
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/median_scheduler.sv
// rtl/median_scheduler.sv - shares one MEDIAN engine between two requesters; MEDIAN_SCHED_TIMEOUT_EN enables WAIT abort
module median_scheduler
    import median_sched_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 100
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ0,
    input  logic            REQ1,
    output logic            GNT0,
    output logic            GNT1,
    input  logic [SIZE-1:0] PIX0,
    input  logic [SIZE-1:0] PIX1,
    input  logic            PV0,
    input  logic            PV1,
    output logic [SIZE-1:0] RES,
    output logic            DONE0,
    output logic            DONE1,
    output logic            ERR0,
    output logic            ERR1,
    output logic [SIZE-1:0] MED_DI,
    output logic            MED_DSI,
    input  logic [SIZE-1:0] MED_DO,
    input  logic            MED_DSO
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             served;
    logic [SIZE-1:0]  buffer [NPIX];
    logic [1:0]       grant;
    logic             accept;
    logic [SIZE-1:0]  pix_in;
    logic             abort;
    logic             update;

    assign accept = (GNT0 & PV0) | (GNT1 & PV1);
    assign pix_in = GNT1 ? PIX1 : PIX0;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;

    assign abort = (state == WAIT) && !MED_DSO && (wcnt == TW'(TIMEOUT - 1));

    // WAIT cycle counter, cleared on every entry into WAIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt <= '0;
        end else if (state != WAIT) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign abort = 1'b0;
`endif

    assign update = (state == WAIT) && (MED_DSO || abort);

    median_rr_arb u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    ({REQ1, REQ0}),
        .update (update),
        .served (served),
        .grant  (grant)
    );

    // pixel buffer; contents are meaningless until a full LOAD completes
    always_ff @(posedge CLK) begin
        if (state == LOAD && accept) begin
            buffer[cnt] <= pix_in;
        end
    end

    // scheduler FSM with registered grant, engine and result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            served  <= 1'b0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            RES     <= '0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
            ERR0    <= 1'b0;
            ERR1    <= 1'b0;
            MED_DI  <= '0;
            MED_DSI <= 1'b0;
        end else begin
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            ERR0  <= 1'b0;
            ERR1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        GNT0   <= grant[0];
                        GNT1   <= grant[1];
                        served <= grant[1];
                        cnt    <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == CNT_W'(NPIX - 1)) begin
                            // last pixel: drop grant and present buffer[0] on the first BURST cycle
                            GNT0    <= 1'b0;
                            GNT1    <= 1'b0;
                            MED_DSI <= 1'b1;
                            MED_DI  <= buffer[0];
                            cnt     <= CNT_W'(1);
                            state   <= BURST;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (cnt == CNT_W'(NPIX)) begin
                        MED_DSI <= 1'b0;
                        MED_DI  <= '0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end else begin
                        MED_DI <= buffer[cnt];
                        cnt    <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (MED_DSO) begin
                        RES   <= MED_DO;
                        DONE0 <= ~served;
                        DONE1 <= served;
                        state <= IDLE;
                    end else if (abort) begin
                        ERR0  <= ~served;
                        ERR1  <= served;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
